asi_arb: RTL and testbench

Single-clock arbiter that shares the user-side memory port between the AXI slave write interface and the AXI slave read interface. It accepts one request/grant pair from each side, grants whole bursts, and holds a grant from the first beat until the beat flagged last. It sits in the user clock domain between the two slave interfaces and the user memory model. Priority is static, with optional anti-starvation.

---
 rtl/asi_arb_if.sv | 26 ++
 rtl/asi_arb.sv | 128 ++++++++++++
 tb/tb_asi_arb.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/asi_arb_if.sv
// Request/grant/beat bundle between the two AXI slave sides and asi_arb.
// The master modport is the requester side; the slave modport is the arbiter.
interface asi_arb_if;
    logic       usr_wrequest;
    logic       usr_we;
    logic       usr_wlast;
    logic       usr_wgrant;
    logic       usr_rrequest;
    logic       usr_re;
    logic       usr_rlast;
    logic       usr_rgrant;
    logic [1:0] arb_owner;
    logic       arb_err;

    modport master (
        output usr_wrequest, usr_we, usr_wlast,
        output usr_rrequest, usr_re, usr_rlast,
        input  usr_wgrant, usr_rgrant, arb_owner, arb_err
    );

    modport slave (
        input  usr_wrequest, usr_we, usr_wlast,
        input  usr_rrequest, usr_re, usr_rlast,
        output usr_wgrant, usr_rgrant, arb_owner, arb_err
    );
endinterface

// File: rtl/asi_arb.sv
// Burst-granular write/read arbiter for the user memory port, static priority.
// Optional anti-starvation counter enabled by defining ASI_ARB_FAIR_EN.
module asi_arb #(
    parameter int ASI_ARB    = 0,
    parameter int STARVE_MAX = 4
) (
    input  logic      usr_clk,
    input  logic      usr_reset,
    asi_arb_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WGNT = 2'b01,
        RGNT = 2'b10
    } state_t;

    state_t state_q, state_d;

    logic pri_is_read;
    logic w_end, r_end, decide;
    logic pri_req, np_req;
    logic np_win, pri_win;
    logic w_sel, r_sel;
    logic force_np;
    logic viol;
    logic err_q;

    assign pri_is_read = (ASI_ARB != 0);

    always_comb begin
        w_end   = 1'b0;
        r_end   = 1'b0;
        decide  = 1'b0;
        pri_req = 1'b0;
        np_req  = 1'b0;
        np_win  = 1'b0;
        pri_win = 1'b0;
        w_sel   = 1'b0;
        r_sel   = 1'b0;
        state_d = state_q;

        w_end  = (state_q == WGNT) && bus.usr_we && bus.usr_wlast;
        r_end  = (state_q == RGNT) && bus.usr_re && bus.usr_rlast;
        decide = (state_q == IDLE) || w_end || r_end;

        pri_req = pri_is_read ? bus.usr_rrequest : bus.usr_wrequest;
        np_req  = pri_is_read ? bus.usr_wrequest : bus.usr_rrequest;
        // Non-priority side wins when alone, or when the starvation limit is hit.
        np_win  = np_req && (!pri_req || force_np);
        pri_win = pri_req && !np_win;

        w_sel = pri_is_read ? np_win  : pri_win;
        r_sel = pri_is_read ? pri_win : np_win;

        if (decide) begin
            if (w_sel)
                state_d = WGNT;
            else if (r_sel)
                state_d = RGNT;
            else
                state_d = IDLE;
        end
    end

    always_ff @(posedge usr_clk) begin
        if (usr_reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

`ifdef ASI_ARB_FAIR_EN
    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    logic [CW-1:0] starve_q, starve_d;

    assign force_np = (starve_q == STARVE_LIM);

    // Count only contested decisions the priority side wins; anything else clears.
    always_comb begin
        starve_d = starve_q;
        if (decide) begin
            if (np_req && !np_win)
                starve_d = starve_q + CW'(1);
            else
                starve_d = '0;
        end
    end

    always_ff @(posedge usr_clk) begin
        if (usr_reset)
            starve_q <= '0;
        else
            starve_q <= starve_d;
    end
`else
    assign force_np = 1'b0;

    if (STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_starve_max_out_of_range
    end
`endif

    always_comb begin
        viol = 1'b0;
        if (bus.usr_we && (state_q != WGNT))
            viol = 1'b1;
        if (bus.usr_re && (state_q != RGNT))
            viol = 1'b1;
        if (bus.usr_wlast && !bus.usr_we)
            viol = 1'b1;
        if (bus.usr_rlast && !bus.usr_re)
            viol = 1'b1;
    end

    always_ff @(posedge usr_clk) begin
        if (usr_reset)
            err_q <= 1'b0;
        else if (viol)
            err_q <= 1'b1;
    end

    assign bus.usr_wgrant = (state_q == WGNT);
    assign bus.usr_rgrant = (state_q == RGNT);
    assign bus.arb_owner  = (state_q == WGNT) ? 2'b01 :
                            (state_q == RGNT) ? 2'b10 : 2'b00;
    assign bus.arb_err    = err_q;
endmodule

// File: tb/tb_asi_arb.sv
// Directed bench for asi_arb: one write-priority and one read-priority instance.
module tb_asi_arb;
    logic usr_clk;
    logic usr_reset;
    int   checks;
    int   errors;

    asi_arb_if ifw ();
    asi_arb_if ifr ();

    asi_arb #(.ASI_ARB(0), .STARVE_MAX(2)) dut_w (
        .usr_clk   (usr_clk),
        .usr_reset (usr_reset),
        .bus       (ifw.slave)
    );

    asi_arb #(.ASI_ARB(1), .STARVE_MAX(4)) dut_r (
        .usr_clk   (usr_clk),
        .usr_reset (usr_reset),
        .bus       (ifr.slave)
    );

    initial usr_clk = 1'b0;
    always #5 usr_clk = ~usr_clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge usr_clk);
        #1;
    endtask

    task automatic idle_inputs();
        ifw.usr_wrequest = 0; ifw.usr_we = 0; ifw.usr_wlast = 0;
        ifw.usr_rrequest = 0; ifw.usr_re = 0; ifw.usr_rlast = 0;
        ifr.usr_wrequest = 0; ifr.usr_we = 0; ifr.usr_wlast = 0;
        ifr.usr_rrequest = 0; ifr.usr_re = 0; ifr.usr_rlast = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        usr_reset = 1;
        tick();
        usr_reset = 0;
    endtask

    logic [1:0] exp_order [6];

    initial begin
        checks = 0;
        errors = 0;
        usr_reset = 1;
        idle_inputs();
        tick();
        tick();
        usr_reset = 0;

        // reset state
        check("rst_wgrant", ifw.usr_wgrant, 0);
        check("rst_rgrant", ifw.usr_rgrant, 0);
        check("rst_owner",  ifw.arb_owner, 0);
        check("rst_err",    ifw.arb_err, 0);
        check("rst_owner_r", ifr.arb_owner, 0);
        tick(); tick();

        // four-beat write burst
        ifw.usr_wrequest = 1;
        tick();
        check("w4_grant", ifw.usr_wgrant, 1);
        check("w4_owner", ifw.arb_owner, 1);
        for (int i = 0; i < 4; i++) begin
            ifw.usr_we    = 1;
            ifw.usr_wlast = (i == 3);
            if (i == 3) ifw.usr_wrequest = 0;
            tick();
            if (i < 3) check("w4_hold", ifw.usr_wgrant, 1);
        end
        idle_inputs();
        check("w4_release", ifw.usr_wgrant, 0);
        check("w4_owner_idle", ifw.arb_owner, 0);
        check("w4_err", ifw.arb_err, 0);

        // simultaneous requests, write priority, direct handoff to read
        ifw.usr_wrequest = 1;
        ifw.usr_rrequest = 1;
        tick();
        check("both_wgrant", ifw.usr_wgrant, 1);
        check("both_rgrant", ifw.usr_rgrant, 0);
        ifw.usr_we = 1; ifw.usr_wlast = 0;
        tick();
        check("both_hold_r", ifw.usr_rgrant, 0);
        ifw.usr_wlast = 1; ifw.usr_wrequest = 0;
        tick();
        check("handoff_wgrant", ifw.usr_wgrant, 0);
        check("handoff_rgrant", ifw.usr_rgrant, 1);
        check("handoff_owner", ifw.arb_owner, 2);
        ifw.usr_we = 0; ifw.usr_wlast = 0;
        ifw.usr_re = 1; ifw.usr_rlast = 1; ifw.usr_rrequest = 0;
        tick();
        idle_inputs();
        check("handoff_done", ifw.arb_owner, 0);

        // read-priority instance: single-beat read, then contested request
        ifr.usr_rrequest = 1;
        tick();
        check("r1_grant", ifr.usr_rgrant, 1);
        ifr.usr_re = 1; ifr.usr_rlast = 1; ifr.usr_rrequest = 0;
        tick();
        idle_inputs();
        check("r1_release", ifr.usr_rgrant, 0);
        check("r1_owner", ifr.arb_owner, 0);
        tick();
        check("r1_idle", ifr.arb_owner, 0);
        ifr.usr_wrequest = 1; ifr.usr_rrequest = 1;
        tick();
        check("rpri_owner", ifr.arb_owner, 2);
        ifr.usr_re = 1; ifr.usr_rlast = 1; ifr.usr_rrequest = 0;
        tick();
        check("rpri_then_w", ifr.arb_owner, 1);
        ifr.usr_re = 0; ifr.usr_rlast = 0;
        ifr.usr_we = 1; ifr.usr_wlast = 1; ifr.usr_wrequest = 0;
        tick();
        idle_inputs();
        check("rpri_idle", ifr.arb_owner, 0);
        check("rpri_err", ifr.arb_err, 0);

        // both held with single-beat bursts
`ifdef ASI_ARB_FAIR_EN
        exp_order = '{2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10};
`else
        exp_order = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
`endif
        ifw.usr_wrequest = 1; ifw.usr_rrequest = 1;
        tick();
        for (int k = 0; k < 6; k++) begin
            check($sformatf("order_%0d", k), ifw.arb_owner, exp_order[k]);
            ifw.usr_we = 0; ifw.usr_wlast = 0; ifw.usr_re = 0; ifw.usr_rlast = 0;
            if (exp_order[k] == 2'b01) begin
                ifw.usr_we = 1; ifw.usr_wlast = 1;
            end else begin
                ifw.usr_re = 1; ifw.usr_rlast = 1;
            end
            if (k == 5) begin
                ifw.usr_wrequest = 0; ifw.usr_rrequest = 0;
            end
            tick();
        end
        idle_inputs();
        check("order_idle", ifw.arb_owner, 0);
        check("order_err", ifw.arb_err, 0);

        // stray read beat sets sticky error, grants untouched
        ifw.usr_re = 1;
        tick();
        ifw.usr_re = 0;
        check("err_set", ifw.arb_err, 1);
        check("err_rgrant", ifw.usr_rgrant, 0);
        check("err_owner", ifw.arb_owner, 0);
        tick(); tick();
        check("err_sticky", ifw.arb_err, 1);
        check("err_other_inst", ifr.arb_err, 0);
        do_reset();
        check("err_cleared", ifw.arb_err, 0);

        // wlast without we: flagged, and the burst is not ended
        ifw.usr_wrequest = 1;
        tick();
        ifw.usr_wrequest = 0;
        ifw.usr_wlast = 1;
        tick();
        ifw.usr_wlast = 0;
        check("lastonly_hold", ifw.usr_wgrant, 1);
        check("lastonly_err", ifw.arb_err, 1);
        do_reset();
        check("lastonly_rst", ifw.arb_owner, 0);

        // reset in the middle of a 16-beat write
        ifw.usr_wrequest = 1;
        tick();
        check("mid_grant", ifw.usr_wgrant, 1);
        for (int i = 0; i < 6; i++) begin
            ifw.usr_we = 1; ifw.usr_wlast = 0;
            tick();
        end
        check("mid_hold", ifw.usr_wgrant, 1);
        idle_inputs();
        usr_reset = 1;
        tick();
        check("mid_rst_wgrant", ifw.usr_wgrant, 0);
        check("mid_rst_owner", ifw.arb_owner, 0);
        usr_reset = 0;
        ifw.usr_rrequest = 1;
        tick();
        check("post_rst_rgrant", ifw.usr_rgrant, 1);
        check("post_rst_err", ifw.arb_err, 0);
        ifw.usr_re = 1; ifw.usr_rlast = 1; ifw.usr_rrequest = 0;
        tick();
        idle_inputs();
        check("post_rst_idle", ifw.arb_owner, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
